// File: rtl/store_monitor_pkg.sv
// Shared types and default signature constants for the store monitor.
// Verdict states plus the addresses/data that end a test program.
package store_monitor_pkg;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } verdict_t;

  localparam logic [31:0] PASS_ADDR   = 32'd50;
  localparam logic [31:0] PASS_DATA   = 32'd0;
  localparam logic [31:0] IGNORE_ADDR = 32'd80;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy counter and sticky overflow.
// Head reads as zero while empty so the output stays stable.
module sync_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a full push needs.
  assign do_push = push & (~full | do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push & full & ~do_pop) overflow <= 1'b1;
    end
  end

endmodule

// File: rtl/store_monitor.sv
// Passive data-memory store observer: trace FIFO, store counter,
// and a sticky pass/fail verdict driven by a signature store.
module store_monitor
  import store_monitor_pkg::*;
#(
  parameter int          DEPTH       = 8,
  parameter logic [31:0] PASS_ADDR   = store_monitor_pkg::PASS_ADDR,
  parameter logic [31:0] PASS_DATA   = store_monitor_pkg::PASS_DATA,
  parameter logic [31:0] IGNORE_ADDR = store_monitor_pkg::IGNORE_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic [15:0] store_count,
  output logic        overflow,
  output logic        pass,
  output logic        fail,
  output logic        done
);

  verdict_t state;
  verdict_t state_nxt;
  logic     push;
  logic     empty;
  logic     full;

  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN: begin
        if (memwrite) begin
          if (dataadr == PASS_ADDR && writedata == PASS_DATA)
            state_nxt = PASS;
          else if (dataadr != IGNORE_ADDR)
            state_nxt = FAIL;
        end
      end
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      store_count <= '0;
    else if (memwrite && store_count != 16'hFFFF)
      store_count <= store_count + 16'd1;
  end

  // The verdict-causing store is still captured: push keys off current state.
  assign push      = memwrite & (state == RUN);
  assign out_valid = ~empty;
  assign pass      = (state == PASS);
  assign fail      = (state == FAIL);
  assign done      = pass | fail;

  sync_fifo #(
    .DATA_W (64),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .push     (push),
    .pop      (out_valid & out_ready),
    .din      ({dataadr, writedata}),
    .dout     ({out_addr, out_data}),
    .full     (full),
    .empty    (empty),
    .overflow (overflow)
  );

  logic unused_full;
  assign unused_full = full;

endmodule

// File: tb/tb_store_monitor.sv
// Directed scoreboard bench for store_monitor.
// Expected stores are queued on drive and popped on drain.
module tb_store_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic [15:0] store_count;
  logic        overflow;
  logic        pass;
  logic        fail;
  logic        done;

  store_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .memwrite    (memwrite),
    .dataadr     (dataadr),
    .writedata   (writedata),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_addr    (out_addr),
    .out_data    (out_data),
    .store_count (store_count),
    .overflow    (overflow),
    .pass        (pass),
    .fail        (fail),
    .done        (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // reference model
  logic [63:0] q[$];
  int          m_state;
  logic        m_ovf;
  int          m_count;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    m_state = 0;
    m_ovf   = 1'b0;
    m_count = 0;
  endtask

  task automatic check_state(input string tag);
    logic [31:0] ea;
    logic [31:0] ed;
    ea = (q.size() > 0) ? q[0][63:32] : 32'd0;
    ed = (q.size() > 0) ? q[0][31:0]  : 32'd0;
    chk({tag, ".pass"},  {31'd0, pass},     {31'd0, m_state == 1});
    chk({tag, ".fail"},  {31'd0, fail},     {31'd0, m_state == 2});
    chk({tag, ".done"},  {31'd0, done},     {31'd0, m_state != 0});
    chk({tag, ".ovf"},   {31'd0, overflow}, {31'd0, m_ovf});
    chk({tag, ".count"}, {16'd0, store_count}, m_count);
    chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, q.size() > 0});
    chk({tag, ".addr"},  out_addr, ea);
    chk({tag, ".data"},  out_data, ed);
  endtask

  task automatic model_store(input logic [31:0] a, input logic [31:0] d,
                             input bit popping);
    if (m_count < 65535) m_count++;
    if (popping && q.size() > 0) void'(q.pop_front());
    if (m_state == 0) begin
      if (q.size() < 8) q.push_back({a, d});
      else m_ovf = 1'b1;
      if (a == 32'd50 && d == 32'd0) m_state = 1;
      else if (a != 32'd80) m_state = 2;
    end
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d);
    memwrite  = 1'b1;
    dataadr   = a;
    writedata = d;
    model_store(a, d, 1'b0);
    tick();
    memwrite = 1'b0;
  endtask

  task automatic drain_all(input string tag);
    int guard;
    guard = 0;
    while (q.size() > 0 && guard < 12) begin
      check_state(tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      void'(q.pop_front());
      guard++;
    end
    check_state({tag, ".empty"});
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #2;
    reset = 1'b1;
    tick();
  endtask

  initial begin
    reset     = 1'b0;
    memwrite  = 1'b0;
    dataadr   = '0;
    writedata = '0;
    out_ready = 1'b0;
    model_reset();
    tick();
    tick();
    check_state("rst");
    reset = 1'b1;
    tick();

    // signature store ends the program with pass
    store(32'd50, 32'd0);
    check_state("sig");
    drain_all("sig_drain");

    // scratch store then signature
    do_reset();
    store(32'd80, 32'd7);
    check_state("scr1");
    store(32'd50, 32'd0);
    check_state("scr2");
    drain_all("scr_drain");

    // wrong data at pass address -> fail, later stores not captured
    do_reset();
    store(32'd50, 32'd5);
    check_state("bad1");
    store(32'd50, 32'd0);
    check_state("bad2");
    drain_all("bad_drain");

    // overflow with drain held off
    do_reset();
    for (int i = 0; i < 9; i++) store(32'd80, 32'(i + 16));
    check_state("ovf");
    drain_all("ovf_drain");

    // full FIFO with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) store(32'd80, 32'(i + 32));
    check_state("full");
    memwrite  = 1'b1;
    dataadr   = 32'd80;
    writedata = 32'd99;
    out_ready = 1'b1;
    model_store(32'd80, 32'd99, 1'b1);
    tick();
    memwrite  = 1'b0;
    out_ready = 1'b0;
    check_state("pushpop");
    drain_all("pp_drain");

    // asynchronous reset mid-cycle with a store in flight
    do_reset();
    store(32'd50, 32'd0);
    check_state("pre_rst");
    memwrite  = 1'b1;
    dataadr   = 32'd80;
    writedata = 32'd1;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_state("async_rst");
    memwrite = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    store(32'd50, 32'd0);
    check_state("post_rst");
    drain_all("post_drain");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
